// File: rtl/apb_cmd_arbiter.sv
// rtl/apb_cmd_arbiter.sv - round-robin arbiter funnelling NUM_REQ command requesters into one downstream APB command port
module apb_cmd_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int RSP_LAT    = 3,
    parameter int TIMEOUT    = 15,
    localparam int CMD_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [NUM_REQ-1:0]           req_vld,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [NUM_REQ-1:0]           rsp_vld,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic [CMD_WIDTH-1:0]         m_cmd,
    output logic                         m_cmd_vld,
    input  logic                         m_cmd_rdy,
    output logic                         m_transfer,
    input  logic [DATA_WIDTH-1:0]        m_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT_W = $clog2(RSP_LAT + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      gnt;
    logic [PTR_W-1:0]      gnt_q;
    logic                  gnt_found;
    int                    scan_idx;
    logic [CMD_WIDTH-1:0]  cmd_q;
    logic [LAT_W-1:0]      lat_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Scan offsets from the far end down so the smallest offset from rr_ptr wins.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        scan_idx  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req_vld[scan_idx]) begin
                gnt       = PTR_W'(scan_idx);
                gnt_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_rdy    = '0;
        rsp_vld    = '0;
        rsp_err    = 1'b0;
        m_cmd      = '0;
        m_cmd_vld  = 1'b0;
        m_transfer = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found && !rst) begin
                    req_rdy[gnt] = 1'b1;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                m_transfer = 1'b1;
                m_cmd_vld  = 1'b1;
                m_cmd      = cmd_q;
                // A handshake on the final allowed cycle still counts as accepted.
                if (m_cmd_rdy) begin
                    state_nxt = WAIT;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nxt = RESP;
                end
            end
            WAIT: begin
                m_transfer = 1'b1;
                if (lat_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                m_transfer     = 1'b1;
                rsp_vld[gnt_q] = 1'b1;
                rsp_err        = err_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            gnt_q   <= '0;
            cmd_q   <= '0;
            lat_cnt <= '0;
            to_cnt  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q  <= gnt;
                        cmd_q  <= req_cmd[int'(gnt)*CMD_WIDTH +: CMD_WIDTH];
                        to_cnt <= '0;
                        err_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (m_cmd_rdy) begin
                        lat_cnt <= LAT_W'(RSP_LAT - 1);
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rdata_q <= cmd_q[CMD_WIDTH-1] ? '0 : m_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// tb/tb_apb_cmd_arbiter.sv - randomized transaction-level checking of apb_cmd_arbiter against a round-robin timing model
module tb_apb_cmd_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int CW  = DW + AW + 1;
    localparam int LAT = 3;
    localparam int TO  = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*CW-1:0] req_cmd;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [CW-1:0]   m_cmd;
    logic            m_cmd_vld;
    logic            m_cmd_rdy;
    logic            m_transfer;
    logic [DW-1:0]   m_rdata;

    int            n_chk = 0;
    int            n_pass = 0;
    int            rr = 0;
    logic [DW-1:0] last_rdata = '0;

    apb_cmd_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .RSP_LAT(LAT), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .m_cmd(m_cmd),
        .m_cmd_vld(m_cmd_vld), .m_cmd_rdy(m_cmd_rdy), .m_transfer(m_transfer), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Rotate the valid mask so rr sits at bit 0, then isolate the lowest set bit.
    function automatic int exp_grant(input logic [N-1:0] mask, input int ptr);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [N-1:0]   low;
        dbl = {mask, mask} >> ptr;
        rot = dbl[N-1:0];
        low = rot & (~rot + 1'b1);
        return (ptr + $clog2(low)) % N;
    endfunction

    function automatic logic [N*CW-1:0] rand_cmds();
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'($urandom);
        return v;
    endfunction

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            req_vld = '0;
            req_cmd = rand_cmds();
            #1;
            check("gap_req_rdy", req_rdy, 0);
            check("gap_rsp_vld", rsp_vld, 0);
            next_cycle();
        end
    endtask

    // Called at a negedge with the DUT idle; delay >= TO forces a timeout.
    task automatic txn(input logic [N-1:0] mask, input logic [N*CW-1:0] cmds,
                       input int delay, input int rd_val);
        int            g;
        logic [CW-1:0] c;
        logic [DW-1:0] exp_rd;
        bit            tmo;
        req_vld   = mask;
        req_cmd   = cmds;
        m_cmd_rdy = 1'b0;
        #1;
        g = exp_grant(mask, rr);
        c = cmds[g*CW +: CW];
        check("accept_req_rdy", req_rdy, 1 << g);
        check("idle_m_transfer", m_transfer, 0);
        next_cycle();
        req_vld = N'($urandom);
        req_cmd = rand_cmds();
        tmo = 1'b1;
        for (int k = 0; k < TO; k++) begin
            m_cmd_rdy = (k == delay);
            m_rdata   = DW'($urandom);
            #1;
            check("issue_m_cmd_vld", m_cmd_vld, 1);
            check("issue_m_cmd", m_cmd, c);
            check("issue_req_rdy", req_rdy, 0);
            next_cycle();
            if (k == delay) begin
                tmo = 1'b0;
                break;
            end
        end
        m_cmd_rdy = 1'b0;
        exp_rd = '0;
        if (!tmo) begin
            for (int k = 0; k < LAT; k++) begin
                m_rdata = (rd_val >= 0) ? DW'(rd_val) : DW'($urandom);
                #1;
                check("wait_m_cmd_vld", m_cmd_vld, 0);
                check("wait_rsp_vld", rsp_vld, 0);
                check("wait_m_transfer", m_transfer, 1);
                if (k == LAT - 1 && !c[CW-1]) exp_rd = m_rdata;
                next_cycle();
            end
        end
        req_vld = '0;
        #1;
        check("rsp_vld", rsp_vld, 1 << g);
        check("rsp_err", rsp_err, tmo);
        check("rsp_rdata", rsp_rdata, exp_rd);
        rr = (g + 1) % N;
        last_rdata = exp_rd;
        next_cycle();
        #1;
        check("post_rsp_vld", rsp_vld, 0);
        check("post_m_transfer", m_transfer, 0);
        check("hold_rsp_rdata", rsp_rdata, last_rdata);
    endtask

    initial begin
        logic [N*CW-1:0] cmds;
        int              g;
        rst       = 1'b1;
        req_vld   = '1;
        req_cmd   = '0;
        m_cmd_rdy = 1'b0;
        m_rdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req_rdy", req_rdy, 0);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_m_cmd_vld", m_cmd_vld, 0);
        check("rst_m_cmd", m_cmd, 0);
        check("rst_m_transfer", m_transfer, 0);
        rst = 1'b0;
        req_vld = '0;
        next_cycle();

        for (int i = 0; i < 5; i++) txn('1, rand_cmds(), 0, -1);

        cmds = rand_cmds();
        cmds[0*CW +: CW] = 17'h112A5;
        txn(4'b0001, cmds, 0, -1);

        cmds = rand_cmds();
        cmds[2*CW +: CW] = {1'b0, 8'h40, 8'h00};
        txn(4'b0100, cmds, 0, 8'h3C);

        txn(4'b0010, rand_cmds(), 0, -1);
        txn(N'($urandom_range(1, 15)), rand_cmds(), TO + 3, -1);
        idle_gap(3);
        txn('1, rand_cmds(), 2, -1);

        for (int i = 0; i < 40; i++) begin
            idle_gap($urandom_range(0, 2));
            txn(N'($urandom_range(1, 15)), rand_cmds(),
                ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, 4), -1);
        end

        req_vld = 4'b0100;
        req_cmd = rand_cmds();
        #1;
        g = exp_grant(4'b0100, rr);
        check("abort_accept", req_rdy, 1 << g);
        next_cycle();
        req_vld   = '0;
        m_cmd_rdy = 1'b1;
        next_cycle();
        m_cmd_rdy = 1'b0;
        #1;
        check("abort_wait_xfer", m_transfer, 1);
        rst     = 1'b1;
        req_vld = '1;
        next_cycle();
        #1;
        check("abort_req_rdy", req_rdy, 0);
        check("abort_rsp_vld", rsp_vld, 0);
        check("abort_rsp_err", rsp_err, 0);
        check("abort_m_cmd_vld", m_cmd_vld, 0);
        check("abort_m_cmd", m_cmd, 0);
        check("abort_m_transfer", m_transfer, 0);
        check("abort_rsp_rdata", rsp_rdata, 0);
        rst = 1'b0;
        rr = 0;
        last_rdata = '0;
        idle_gap(4);
        txn('1, rand_cmds(), 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
